// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction-memory write port bundle for imem_loader
interface imem_loader_if #(
  parameter int AW = 8
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  // Host side: produces the byte stream, observes the memory write port.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader writing a byte stream into instruction memory; trailing XOR checksum byte enabled by IMEM_LOADER_CHKSUM_EN
module imem_loader #(
  parameter int AW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  // Largest image the memory can hold; a length byte of 0 means 256 words.
  localparam logic [8:0] MAX_WORDS = (AW >= 8) ? 9'd256 : 9'(1 << AW);

`ifdef IMEM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_DONE = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [8:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic          we_q;
  logic          rdy;
  logic          take;
  logic [8:0]    len_words;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]    chk_q;
`endif

  // Ready is forced low while reset is held so no byte is consumed mid-reset.
  assign bus.in_ready   = rdy & rst;
  assign take           = bus.in_valid & rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

`ifdef IMEM_LOADER_CHKSUM_EN
  assign err = (state_q == S_ERR);
`else
  assign err = 1'b0;
`endif

  // Decode the length byte into a word count, clipped to the memory size.
  always_comb begin
    len_words = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
    if (len_words > MAX_WORDS) len_words = MAX_WORDS;
  end

  // State register; reset parks the loader waiting for a length byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LEN;
    else      state_q <= state_d;
  end

  // Next-state and status decode; the CPU is only released in DONE.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    cpu_rst = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_LEN: begin
        rdy = 1'b1;
        if (take) state_d = S_HI;
      end
      S_HI: begin
        rdy = 1'b1;
        if (take) state_d = S_LO;
      end
      S_LO: begin
        rdy = 1'b1;
        if (take) begin
          if (cnt_q != 9'd1) state_d = S_HI;
`ifdef IMEM_LOADER_CHKSUM_EN
          else               state_d = S_CHK;
`else
          else               state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHK: begin
        rdy = 1'b1;
        if (take) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
      end
      S_ERR: begin
        if (start) state_d = S_LEN;
      end
`endif
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) state_d = S_LEN;
      end
      default: state_d = S_LEN;
    endcase
  end

  // Word assembly, write strobe and address/count bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + AW'(1);
      if (take) begin
        case (state_q)
          S_LEN: begin
            cnt_q  <= len_words;
            addr_q <= '0;
          end
          S_HI: wdata_q[15:8] <= bus.in_data;
          S_LO: begin
            wdata_q[7:0] <= bus.in_data;
            we_q         <= 1'b1;
            cnt_q        <= cnt_q - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  // Running XOR of every byte before the checksum; cleared when re-armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= 8'd0;
    end else if ((state_q == S_DONE || state_q == S_ERR) && start) begin
      chk_q <= 8'd0;
    end else if (take && state_q != S_CHK) begin
      chk_q <= chk_q ^ bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic cpu_rst, done, err;

  imem_loader_if #(.AW(AW)) bus();

  imem_loader #(.AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.slave),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [23:0] exp_q [$];
  logic [23:0] exp_w;
  logic        prev_we = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
  bit          use_bad  = 1'b0;
  logic [7:0]  bad_byte = 8'h00;
`endif

  // Instruction memory model
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) mem[bus.imem_addr] = bus.imem_wdata;
  end

  // Monitor: every write strobe is matched against the scoreboard queue
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_pulse: imem_we high two cycles in a row at addr %h, required single-cycle strobe", bus.imem_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %h data %h, required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== exp_w)
          begin
            errors++;
            $display("FAIL write: got addr %h data %h, required addr %h data %h",
                     bus.imem_addr, bus.imem_wdata, exp_w[23:16], exp_w[15:0]);
          end
      end
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // Present one byte and hold it until accepted; returns #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Stream a full image of nw words from img[] with length byte l
  task automatic load(input logic [7:0] l, input int nw, input bit gap);
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] x;
    x = l;
`endif
    send_byte(l, gap);
    chk("load_cpu_rst", 32'(cpu_rst), 1);
    for (int i = 0; i < nw; i++) begin
      send_byte(img[i][15:8], gap);
      exp_q.push_back({i[7:0], img[i]});
      send_byte(img[i][7:0], gap);
`ifdef IMEM_LOADER_CHKSUM_EN
      x = x ^ img[i][15:8] ^ img[i][7:0];
`endif
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    send_byte(use_bad ? bad_byte : x, gap);
`endif
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"},     32'(done),         1);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),      0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_err"},      32'(err),          0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_in_ready",   32'(bus.in_ready),   0);
    chk("rst_cpu_rst",    32'(cpu_rst),        1);
    chk("rst_imem_we",    32'(bus.imem_we),    0);
    chk("rst_imem_addr",  32'(bus.imem_addr),  0);
    chk("rst_imem_wdata", 32'(bus.imem_wdata), 0);
    chk("rst_done",       32'(done),           0);
    chk("rst_err",        32'(err),            0);
    rst = 1'b1;
    #1;
    chk("len_in_ready", 32'(bus.in_ready), 1);
    chk("len_cpu_rst",  32'(cpu_rst),      1);

    // Basic load
    img[0] = 16'h2301;
    img[1] = 16'h21C2;
    load(8'h02, 2, 1'b0);
    check_done("basic");
    settle();
    chk("basic_mem0", 32'(mem[0]), 32'h2301);
    chk("basic_mem1", 32'(mem[1]), 32'h21C2);

    // Valid while not ready is ignored
    bus.in_data  = 8'h01;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("idle_done", 32'(done), 1);

    // Re-arm
    pulse_start();
    chk("rearm_cpu_rst",  32'(cpu_rst),        1);
    chk("rearm_done",     32'(done),           0);
    chk("rearm_in_ready", 32'(bus.in_ready),   1);
    img[0] = 16'h8003;
    load(8'h01, 1, 1'b0);
    check_done("rearm");
    settle();
    chk("rearm_mem0", 32'(mem[0]), 32'h8003);

    // Backpressured source
    pulse_start();
    img[0] = 16'h2301;
    img[1] = 16'h21C2;
    load(8'h02, 2, 1'b1);
    check_done("bp");
    settle();
    chk("bp_mem0", 32'(mem[0]), 32'h2301);
    chk("bp_mem1", 32'(mem[1]), 32'h21C2);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Checksum failure
    pulse_start();
    img[0]   = 16'h1234;
    use_bad  = 1'b1;
    bad_byte = 8'h00;
    load(8'h01, 1, 1'b0);
    use_bad  = 1'b0;
    chk("cks_err",      32'(err),          1);
    chk("cks_cpu_rst",  32'(cpu_rst),      1);
    chk("cks_done",     32'(done),         0);
    chk("cks_in_ready", 32'(bus.in_ready), 0);
    settle();
    chk("cks_mem0", 32'(mem[0]), 32'h1234);
    pulse_start();
    chk("cks_rearm_err", 32'(err), 0);
    load(8'h01, 1, 1'b0);
    check_done("cks_rearm");
`endif

    // Reset mid-image, after the high byte of the third word
    pulse_start();
    img[0] = 16'h1111;
    img[1] = 16'h2222;
    img[2] = 16'h3333;
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][15:8], 1'b0);
      exp_q.push_back({i[7:0], img[i]});
      send_byte(img[i][7:0], 1'b0);
    end
    pulse_start();
    chk("mid_start_ignored", 32'(bus.in_ready), 1);
    send_byte(img[2][15:8], 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_imem_we",  32'(bus.imem_we),  0);
    chk("mid_cpu_rst",  32'(cpu_rst),      1);
    chk("mid_in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_len_ready", 32'(bus.in_ready), 1);
    chk("mid_queue",     32'(exp_q.size()), 0);
    chk("mid_mem1_kept", 32'(mem[1]), 32'h2222);
    img[0] = 16'hA000;
    load(8'h01, 1, 1'b0);
    check_done("mid_reload");
    settle();
    chk("mid_mem0", 32'(mem[0]), 32'hA000);
    chk("mid_mem1", 32'(mem[1]), 32'h2222);

    // Length 0 loads 256 words
    pulse_start();
    for (int i = 0; i < 256; i++) img[i] = {i[7:0] ^ 8'h5A, i[7:0]};
    load(8'h00, 256, 1'b0);
    check_done("len0");
    settle();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
    chk("len0_mem_bad_words", 32'(bad), 0);
    chk("len0_addr_wrap", 32'(bus.imem_addr), 0);

    settle();
    chk("final_queue", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the 16-bit single-cycle datapath. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into instruction memory from address 0 upward. It holds the datapath in reset until the image is fully written. It is the hardware replacement for preloading instruction memory directly from the bench, and sits between the host byte link and the instruction-memory write port.

## Interface

Parameters:
- `AW`, default 8: instruction-memory address width; maximum image is 2^AW words.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; re-arms the loader from DONE or ERR.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a byte when `in_valid` and `in_ready` are both high.
- `imem_we`, out, 1: instruction-memory write strobe, one cycle per word.
- `imem_addr`, out, AW: write address.
- `imem_wdata`, out, 16: write data.
- `cpu_rst`, out, 1: active-high reset to the datapath, matching the datapath's `rst` polarity.
- `done`, out, 1: image loaded; CPU released.
- `err`, out, 1: load failed; CPU held in reset (only with the checksum feature compiled in).

## Operation

Stream format: a length byte L giving the word count (0 means 256, clipped to 2^AW), then 2×L bytes per word with the high byte first.

States:
- **LEN**: the reset state. `in_ready`=1. On accept, load the word counter with L and clear the address.
- **HI**: `in_ready`=1. On accept, latch `in_data` into `wdata[15:8]`.
- **LO**: `in_ready`=1. On accept, latch `wdata[7:0]` and schedule the write.
  - If more words remain, go to HI.
  - Otherwise go to CHK if the checksum feature is compiled in, else DONE.
- **CHK** (checksum feature only): `in_ready`=1. On accept:
  - byte == running XOR → DONE;
  - byte ≠ running XOR → ERR.
- **DONE**: `in_ready`=0, `done`=1, `cpu_rst`=0. A `start` pulse goes to LEN.
- **ERR**: `in_ready`=0, `err`=1, `cpu_rst`=1. A `start` pulse goes to LEN.

Write port and counters:
- `imem_addr` is the index of the word being written. It increments after each write and wraps modulo 2^AW.
- `cpu_rst`=1 in every state except DONE.
- `start` has no effect in LEN, HI, LO or CHK.
- `in_valid` without `in_ready` has no effect; bytes are never dropped or duplicated.

Reset values: state=LEN, `in_ready`=0 during reset then 1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0, counters=0, checksum=0.

## Timing

- Throughput is one byte per cycle; `in_ready` is never dropped mid-image.
- Word write: the LO byte is accepted at edge k. At edge k+1, `imem_we`=1 with the final addr and data, for exactly one cycle.
- Release: the final byte (LO, or CHK when compiled in) is accepted at edge k. At edge k+1 the state is DONE and `cpu_rst` falls, coincident with the last write strobe. The datapath therefore fetches `mem[0]` no earlier than edge k+2.
- `start` at edge k moves to LEN. At edge k+1, `cpu_rst`=1 and `done`/`err`=0.
- Asynchronous `rst` mid-image aborts immediately: `imem_we` drops, `cpu_rst`=1, and the partial image is not cleared. Loading restarts at a length byte.

## Configuration

- `IMEM_LOADER_CHKSUM_EN` defined:
  - The stream ends with one extra byte equal to the XOR of all preceding bytes, including L.
  - The checksum accumulator is cleared on entry to LEN.
  - A mismatch goes to ERR; written words remain in memory, but the CPU stays in reset.
- `IMEM_LOADER_CHKSUM_EN` undefined:
  - No CHK state, and `err` is tied to 0.
  - LO for the last word goes directly to DONE.

## Test plan

- **Basic load:** rst low for 4 cycles, then stream 0x02, 0x23, 0x01, 0x21, 0xC2 (plus checksum 0xC3 when enabled). Expect `mem[0]`=0x2301 and `mem[1]`=0x21C2, two single-cycle `imem_we` pulses, then `done`=1 and `cpu_rst`=0 on the edge after the last byte.
- **Backpressured source:** same image with `in_valid` toggled every other cycle. Expect identical memory contents, and `imem_we` never high more than one consecutive cycle.
- **Checksum failure (macro on):** send 0x01, 0x12, 0x34, 0x00 (correct value is 0x27). Expect `mem[0]`=0x1234, `err`=1, `cpu_rst`=1, `done`=0, `in_ready`=0.
- **Reset mid-image:** assert rst after the HI byte of word 3. Expect `imem_we`=0, `cpu_rst`=1, state LEN. A fresh 1-word load of 0xA000 then writes address 0.
- **Re-arm:** after DONE, pulse `start`. Expect `cpu_rst`=1 on the next cycle, then a new 1-word load of 0x8003 overwrites `mem[0]` and returns to DONE.
- **Length 0:** with AW=8, L=0x00 loads 256 words. Expect addresses 0..255 written once each, `imem_addr` wrapping to 0, and `done` after byte 513 (or 514 with checksum).
